tunnel_bram_sched: RTL and testbench
====================================

Name: tunnel_bram_sched

Overview:
Single-port arbiter and sequencer for the tunnel row BRAM. The BRAM is shared between two requesters:
- the VGA display fetcher, which needs one 72-bit row per scanline of the game area;
- the Tunnel game engine, which reads and writes rows.

The block also issues a per-frame step tick to the engine. It holds write commits back until the display window has ended, which prevents tearing. It sits between sync_gen50, Tunnel and the BRAM instance in vga_cruiser_top.

Parameters:
ADDR_W, 6, BRAM row address width (64 rows)
DATA_W, 72, BRAM row width
Y_TOP, 113, first visible game-area scanline
ROWS, 64, game-area scanlines (one BRAM row each)
H_FETCH, 1290, XPos at which the next line's row is fetched (horizontal blank)
V_ACTIVE, 480, first vertical-blank line (frame tick line)

Ports:
clock  in  1  system clock (50 MHz)
resetn  in  1  asynchronous active-low reset
xpos  in  11  sync_gen50 CounterX
ypos  in  10  sync_gen50 CounterY
frame_tick  out  1  one-cycle pulse at start of vertical blank; Tunnel step enable
disp_row_data  out  DATA_W  row for the current/next game-area scanline
disp_row_valid  out  1  disp_row_data holds a row fetched this frame
eng_req  in  1  engine access request; held until eng_gnt
eng_we  in  1  1 = write, 0 = read (stable while eng_req)
eng_addr  in  ADDR_W  engine row address (stable while eng_req)
eng_wdata  in  DATA_W  engine write data (stable while eng_req)
eng_gnt  out  1  one-cycle pulse: access issued to BRAM this cycle
eng_rvalid  out  1  one-cycle pulse the cycle after a read grant
eng_rdata  out  DATA_W  equals bram_rdata; meaningful only when eng_rvalid
bram_en, bram_we  out  1 each  BRAM port controls (registered)
bram_addr  out  ADDR_W  BRAM address (registered)
bram_wdata  out  DATA_W  BRAM write data (registered)
bram_rdata  in  DATA_W  BRAM read data, valid one cycle after bram_en

Behaviour:
- Reset (resetn low, asynchronous):
  - all outputs 0;
  - FSM to IDLE;
  - disp_row_data cleared.
  - A reset mid-access drops that access: no gnt, no rvalid, no capture.
- fetch_hit (combinational): xpos == H_FETCH and Y_TOP-1 <= ypos <= Y_TOP+ROWS-2.
  - Fetched row = ypos-(Y_TOP-1), truncated to ADDR_W.
- write_window: ypos < Y_TOP-1 or ypos >= Y_TOP+ROWS. Engine writes are granted only inside the window. Reads are granted anywhere.
- Arbitration at each edge, display has absolute priority:
  - if fetch_hit: bram_en=1, bram_we=0, bram_addr=row; FSM -> FETCH; eng_gnt=0 this cycle.
  - else if eng_req and (!eng_we or write_window): bram_en=1, bram_we=eng_we, bram_addr=eng_addr, bram_wdata=eng_wdata; eng_gnt=1; remember read/write.
  - else: bram_en=0, bram_we=0.
- FSM states:
  - IDLE.
  - FETCH (BRAM access cycle) -> CAPTURE.
  - CAPTURE: disp_row_data <= bram_rdata; disp_row_valid <= 1 -> IDLE.
  - Fetch latency: bram_en one cycle after xpos==H_FETCH is sampled; disp_row_data updates two cycles after that.
  - The engine may be granted during CAPTURE; the port is free then.
- eng_rvalid=1 exactly one cycle after a read grant; never after a write grant.
- Back-to-back grants are allowed, one access per cycle.
- frame_tick: registered pulse, high for exactly one cycle after the edge sampling xpos==0 and ypos==V_ACTIVE. The same edge clears disp_row_valid.
- Simultaneous fetch_hit and eng_req: the engine waits exactly one cycle, then is granted if still eligible.
- eng_req with eng_we=1 outside write_window: gnt is withheld, without limit, until write_window opens.
- eng_req deasserted before gnt: legal; nothing is issued.
- xpos/ypos beyond the counter range: no fetch, no tick. Arbitration of the engine continues.
- Address wrap: a fetched row is taken mod 2^ADDR_W. There is no overflow for ROWS <= 64.

Decomposition:
- Shared package tunnel_pkg holds:
  - TUNNEL_ADDR_W and TUNNEL_DATA_W;
  - the VGA timing constants (H_FETCH, V_ACTIVE, Y_TOP, ROWS);
  - the FSM state encoding (IDLE, FETCH, CAPTURE).
- One natural sub-module: tunnel_scan_window. It computes fetch_hit, row, write_window and the frame-tick condition from xpos/ypos, and contains no state.
- The arbiter and FSM stay in tunnel_bram_sched.

Test Plan:
1. Fetch at line start:
   - Stimulus: ypos=112, xpos=1290, BRAM row 0 preloaded 72'hA5.
   - Response: bram_en=1 with addr 0 one cycle later; disp_row_data=72'hA5 and disp_row_valid=1 two cycles after that.
   - Repeat at ypos=175: addr 63, then no fetch at ypos=176.
2. Simultaneous conflict:
   - Stimulus: eng_req read at addr 5 asserted on the same edge as fetch_hit.
   - Response: fetch is issued first; eng_gnt the next cycle with bram_addr=5; eng_rvalid the cycle after that.
3. Write blocking:
   - Stimulus: eng_req write to addr 9 at ypos=130.
   - Response: no gnt through line 176. gnt on the first cycle of ypos=177, bram_we=1, addr 9. No eng_rvalid.
4. Frame tick:
   - Stimulus: sweep a full frame (1588x528).
   - Response: exactly one frame_tick, one cycle after xpos=0/ypos=480 is sampled; disp_row_valid=0 afterwards.
5. Reset mid-fetch:
   - Stimulus: drop resetn in the FETCH cycle.
   - Response: all outputs 0 immediately; disp_row_data=0; no capture after release.
6. Back-to-back engine reads:
   - Stimulus: 4 consecutive reads (addr 0–3) during vblank.
   - Response: 4 consecutive gnt pulses, then 4 eng_rvalid pulses with matching data, each one cycle after its grant.

Source files
------------

// File: rtl/tunnel_pkg.sv
// Shared constants and FSM encoding for the tunnel row BRAM scheduler.
// Holds no logic of its own; the timing constants follow the sync_gen50 counters.
package tunnel_pkg;
    localparam int TUNNEL_ADDR_W = 6;
    localparam int TUNNEL_DATA_W = 72;
    localparam int H_FETCH       = 1290;
    localparam int V_ACTIVE      = 480;
    localparam int Y_TOP         = 113;
    localparam int ROWS          = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2
    } sched_state_t;
endpackage

// File: rtl/tunnel_scan_window.sv
// Decodes the scan position into fetch / write-window / frame-tick conditions.
// Purely combinational (zero latency); it never stalls anything.
module tunnel_scan_window
    import tunnel_pkg::*;
#(
    parameter int ADDR_W   = TUNNEL_ADDR_W,
    parameter int Y_TOP_P  = Y_TOP,
    parameter int ROWS_P   = ROWS,
    parameter int H_FETCH_P  = H_FETCH,
    parameter int V_ACTIVE_P = V_ACTIVE
) (
    input  logic [10:0]       xpos,
    input  logic [9:0]        ypos,
    output logic              fetch_hit,
    output logic [ADDR_W-1:0] fetch_row,
    output logic              write_window,
    output logic              tick_hit
);
    // The row for line N is fetched during the blanking of line N-1.
    localparam logic [9:0]  Y_FIRST = 10'(Y_TOP_P - 1);
    localparam logic [9:0]  Y_LAST  = 10'(Y_TOP_P + ROWS_P - 2);
    localparam logic [9:0]  Y_END   = 10'(Y_TOP_P + ROWS_P);
    localparam logic [9:0]  Y_VBL   = 10'(V_ACTIVE_P);
    localparam logic [10:0] X_FETCH = 11'(H_FETCH_P);

    always_comb begin
        fetch_hit    = (xpos == X_FETCH) && (ypos >= Y_FIRST) && (ypos <= Y_LAST);
        fetch_row    = ADDR_W'(ypos - Y_FIRST);
        write_window = (ypos < Y_FIRST) || (ypos >= Y_END);
        tick_hit     = (xpos == 11'd0) && (ypos == Y_VBL);
    end
endmodule

// File: rtl/tunnel_bram_sched.sv
// Single-port BRAM arbiter: display fetch has absolute priority, engine writes wait for the write window.
// BRAM controls one cycle after the decision, row capture two cycles after bram_en; requester must drop or advance eng_req while eng_gnt is high.
module tunnel_bram_sched
    import tunnel_pkg::*;
#(
    parameter int ADDR_W     = TUNNEL_ADDR_W,
    parameter int DATA_W     = TUNNEL_DATA_W,
    parameter int Y_TOP_P    = Y_TOP,
    parameter int ROWS_P     = ROWS,
    parameter int H_FETCH_P  = H_FETCH,
    parameter int V_ACTIVE_P = V_ACTIVE
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [10:0]       xpos,
    input  logic [9:0]        ypos,
    output logic              frame_tick,
    output logic [DATA_W-1:0] disp_row_data,
    output logic              disp_row_valid,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);
    logic              fetch_hit;
    logic [ADDR_W-1:0] fetch_row;
    logic              write_window;
    logic              tick_hit;

    tunnel_scan_window #(
        .ADDR_W     (ADDR_W),
        .Y_TOP_P    (Y_TOP_P),
        .ROWS_P     (ROWS_P),
        .H_FETCH_P  (H_FETCH_P),
        .V_ACTIVE_P (V_ACTIVE_P)
    ) u_scan_window (
        .xpos         (xpos),
        .ypos         (ypos),
        .fetch_hit    (fetch_hit),
        .fetch_row    (fetch_row),
        .write_window (write_window),
        .tick_hit     (tick_hit)
    );

    sched_state_t      state_q, state_d;
    logic              bram_en_q, bram_en_d;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0] bram_wdata_q, bram_wdata_d;
    logic              eng_gnt_q, eng_gnt_d;
    logic              eng_rvalid_q, eng_rvalid_d;
    logic              frame_tick_q, frame_tick_d;
    logic [DATA_W-1:0] disp_row_data_q, disp_row_data_d;
    logic              disp_row_valid_q, disp_row_valid_d;

    always_comb begin
        state_d          = state_q;
        bram_en_d        = 1'b0;
        bram_we_d        = 1'b0;
        bram_addr_d      = bram_addr_q;
        bram_wdata_d     = bram_wdata_q;
        eng_gnt_d        = 1'b0;
        // bram_we_q still describes the access granted last cycle.
        eng_rvalid_d     = eng_gnt_q && !bram_we_q;
        frame_tick_d     = tick_hit;
        disp_row_data_d  = disp_row_data_q;
        disp_row_valid_d = disp_row_valid_q;

        case (state_q)
            FETCH:   state_d = CAPTURE;
            CAPTURE: begin
                disp_row_data_d  = bram_rdata;
                disp_row_valid_d = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fetch_hit) begin
            bram_en_d   = 1'b1;
            bram_addr_d = fetch_row;
            state_d     = FETCH;
        end else if (eng_req && (!eng_we || write_window)) begin
            bram_en_d    = 1'b1;
            bram_we_d    = eng_we;
            bram_addr_d  = eng_addr;
            bram_wdata_d = eng_wdata;
            eng_gnt_d    = 1'b1;
        end

        if (tick_hit) begin
            disp_row_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q          <= IDLE;
            bram_en_q        <= 1'b0;
            bram_we_q        <= 1'b0;
            bram_addr_q      <= '0;
            bram_wdata_q     <= '0;
            eng_gnt_q        <= 1'b0;
            eng_rvalid_q     <= 1'b0;
            frame_tick_q     <= 1'b0;
            disp_row_data_q  <= '0;
            disp_row_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            bram_en_q        <= bram_en_d;
            bram_we_q        <= bram_we_d;
            bram_addr_q      <= bram_addr_d;
            bram_wdata_q     <= bram_wdata_d;
            eng_gnt_q        <= eng_gnt_d;
            eng_rvalid_q     <= eng_rvalid_d;
            frame_tick_q     <= frame_tick_d;
            disp_row_data_q  <= disp_row_data_d;
            disp_row_valid_q <= disp_row_valid_d;
        end
    end

    assign bram_en        = bram_en_q;
    assign bram_we        = bram_we_q;
    assign bram_addr      = bram_addr_q;
    assign bram_wdata     = bram_wdata_q;
    assign eng_gnt        = eng_gnt_q;
    assign eng_rvalid     = eng_rvalid_q;
    assign eng_rdata      = bram_rdata;
    assign frame_tick     = frame_tick_q;
    assign disp_row_data  = disp_row_data_q;
    assign disp_row_valid = disp_row_valid_q;
endmodule

// File: tb/tb_tunnel_bram_sched.sv
// Scoreboard bench for tunnel_bram_sched with a behavioural single-port BRAM.
// Stimulus queues expected BRAM accesses and read data; a negedge monitor pops and compares.
module tb_tunnel_bram_sched;
    localparam int AW = 6;
    localparam int DW = 72;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [10:0]   xpos = '0;
    logic [9:0]    ypos = '0;
    logic          eng_req = 1'b0;
    logic          eng_we = 1'b0;
    logic [AW-1:0] eng_addr = '0;
    logic [DW-1:0] eng_wdata = '0;
    logic [DW-1:0] bram_rdata = '0;

    logic          frame_tick, disp_row_valid, eng_gnt, eng_rvalid, bram_en, bram_we;
    logic [DW-1:0] disp_row_data, eng_rdata, bram_wdata;
    logic [AW-1:0] bram_addr;

    typedef struct packed {
        logic          gnt;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    acc_t          acc_q[$];
    logic [DW-1:0] rd_q[$];
    int            checks = 0;
    int            errors = 0;
    int            tick_cnt = 0;
    logic          prev_rd_gnt = 1'b0;
    logic [DW-1:0] wr_mem [64];
    logic [63:0]   wr_vld = '0;

    tunnel_bram_sched dut (
        .clock          (clock),
        .resetn         (resetn),
        .xpos           (xpos),
        .ypos           (ypos),
        .frame_tick     (frame_tick),
        .disp_row_data  (disp_row_data),
        .disp_row_valid (disp_row_valid),
        .eng_req        (eng_req),
        .eng_we         (eng_we),
        .eng_addr       (eng_addr),
        .eng_wdata      (eng_wdata),
        .eng_gnt        (eng_gnt),
        .eng_rvalid     (eng_rvalid),
        .eng_rdata      (eng_rdata),
        .bram_en        (bram_en),
        .bram_we        (bram_we),
        .bram_addr      (bram_addr),
        .bram_wdata     (bram_wdata),
        .bram_rdata     (bram_rdata)
    );

    always #5 clock = ~clock;

    // Preloaded BRAM image; row 0 holds the test pattern A5.
    function automatic logic [DW-1:0] pre(input int a);
        if (a == 0) return 72'hA5;
        return {8'(a), 32'hC0DE_0000, 32'(a * 3 + 1)};
    endfunction

    always @(posedge clock) begin
        if (bram_en) begin
            if (bram_we) begin
                wr_mem[bram_addr] <= bram_wdata;
                wr_vld[bram_addr] <= 1'b1;
            end else begin
                bram_rdata <= wr_vld[bram_addr] ? wr_mem[bram_addr] : pre(int'(bram_addr));
            end
        end
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic exp_acc(input logic g, input logic w, input int a, input logic [DW-1:0] d);
        acc_t e;
        e.gnt   = g;
        e.we    = w;
        e.addr  = AW'(a);
        e.wdata = w ? d : '0;
        acc_q.push_back(e);
    endtask

    task automatic monitor_cycle();
        acc_t          e;
        logic [79:0]   act;
        logic [DW-1:0] r;
        if (!resetn) begin
            prev_rd_gnt = 1'b0;
            return;
        end
        if (bram_en) begin
            if (acc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_access got addr=%0d we=%0b gnt=%0b want none", bram_addr, bram_we, eng_gnt);
            end else begin
                e   = acc_q.pop_front();
                act = {eng_gnt, bram_we, bram_addr, (bram_we ? bram_wdata : {DW{1'b0}})};
                chk("bram_access", 96'(act), 96'(e));
            end
        end
        if (eng_rvalid || prev_rd_gnt) begin
            chk("rvalid_timing", 96'(eng_rvalid), 96'(prev_rd_gnt));
            if (eng_rvalid) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid got data=%0h want none", eng_rdata);
                end else begin
                    r = rd_q.pop_front();
                    chk("eng_rdata", 96'(eng_rdata), 96'(r));
                end
            end
        end
        prev_rd_gnt = eng_gnt && bram_en && !bram_we;
        if (frame_tick) tick_cnt++;
    endtask

    always @(negedge clock) monitor_cycle();

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive(input int x, input int y);
        xpos = 11'(x);
        ypos = 10'(y);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [DW-1:0] wd;
        wd = 72'h12_3456_789A_BCDE_F012;

        // Reset state
        step(2);
        chk("rst_ctrl", 96'({frame_tick, disp_row_valid, eng_gnt, eng_rvalid, bram_en, bram_we}), 96'(0));
        chk("rst_disp", 96'(disp_row_data), 96'(0));
        resetn = 1'b1;
        step(2);

        // 1: fetch at line start, last row, and no fetch past the area
        drive(1290, 112);
        exp_acc(1'b0, 1'b0, 0, '0);
        step(1);
        drive(1291, 112);
        chk("t1_valid_before", 96'(disp_row_valid), 96'(0));
        step(1);
        chk("t1_not_yet", 96'(disp_row_data), 96'(0));
        step(1);
        chk("t1_disp_data", 96'(disp_row_data), 96'(72'hA5));
        chk("t1_disp_valid", 96'(disp_row_valid), 96'(1));
        drive(1290, 175);
        exp_acc(1'b0, 1'b0, 63, '0);
        step(1);
        drive(1291, 175);
        step(2);
        chk("t1_row63", 96'(disp_row_data), 96'(pre(63)));
        drive(1290, 176);
        step(1);
        drive(1291, 176);
        step(3);
        chk("t1_no_fetch_176", 96'(disp_row_data), 96'(pre(63)));

        // 2: engine read colliding with a fetch
        drive(1290, 120);
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 6'd5;
        exp_acc(1'b0, 1'b0, 8, '0);
        exp_acc(1'b1, 1'b0, 5, '0);
        rd_q.push_back(pre(5));
        step(1);
        drive(1291, 120);
        chk("t2_gnt_deferred", 96'(eng_gnt), 96'(0));
        step(1);
        chk("t2_gnt", 96'(eng_gnt), 96'(1));
        chk("t2_addr", 96'(bram_addr), 96'(5));
        eng_req = 1'b0;
        step(1);
        chk("t2_disp_row8", 96'(disp_row_data), 96'(pre(8)));
        chk("t2_rvalid", 96'(eng_rvalid), 96'(1));
        step(2);

        // 3: write held back until the window opens on line 177
        eng_req = 1'b1; eng_we = 1'b1; eng_addr = 6'd9; eng_wdata = wd;
        for (int y = 130; y <= 176; y++) begin
            drive(0, y);
            step(2);
        end
        drive(0, 177);
        exp_acc(1'b1, 1'b1, 9, wd);
        step(1);
        chk("t3_gnt_177", 96'(eng_gnt), 96'(1));
        chk("t3_we", 96'(bram_we), 96'(1));
        eng_req = 1'b0; eng_we = 1'b0;
        step(2);
        eng_req = 1'b1; eng_addr = 6'd9;
        exp_acc(1'b1, 1'b0, 9, '0);
        rd_q.push_back(wd);
        step(1);
        eng_req = 1'b0;
        step(3);

        // 6: four back-to-back reads in vertical blank
        drive(0, 490);
        for (int i = 0; i < 4; i++) begin
            eng_req = 1'b1; eng_we = 1'b0; eng_addr = AW'(i);
            exp_acc(1'b1, 1'b0, i, '0);
            rd_q.push_back(pre(i));
            step(1);
            chk("t6_gnt", 96'(eng_gnt), 96'(1));
        end
        eng_req = 1'b0;
        step(3);
        chk("t6_rd_drained", 96'(rd_q.size()), 96'(0));

        // 4: frame tick across the vblank boundary lines
        chk("t4_valid_pre", 96'(disp_row_valid), 96'(1));
        base = tick_cnt;
        for (int y = 479; y <= 481; y++) begin
            for (int x = 0; x < 1588; x++) begin
                drive(x, y);
                step(1);
                if (y == 480 && x == 0) begin
                    chk("t4_tick", 96'(frame_tick), 96'(1));
                    chk("t4_valid_clr", 96'(disp_row_valid), 96'(0));
                end
                if (y == 480 && x == 1) chk("t4_tick_width", 96'(frame_tick), 96'(0));
            end
        end
        drive(1290, 700);
        step(2);
        drive(0, 1000);
        step(2);
        chk("t4_tick_count", 96'(tick_cnt - base), 96'(1));

        // 5: reset dropped during the fetch cycle
        drive(1290, 130);
        step(1);
        resetn = 1'b0;
        #1;
        chk("t5_rst_ctrl", 96'({frame_tick, disp_row_valid, eng_gnt, eng_rvalid, bram_en, bram_we}), 96'(0));
        chk("t5_rst_disp", 96'(disp_row_data), 96'(0));
        drive(1291, 130);
        step(2);
        resetn = 1'b1;
        step(4);
        chk("t5_no_capture", 96'(disp_row_data), 96'(0));
        chk("t5_valid", 96'(disp_row_valid), 96'(0));

        chk("acc_drained", 96'(acc_q.size()), 96'(0));
        chk("rd_drained", 96'(rd_q.size()), 96'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
